// File: rtl/jtbubl_prog_if.sv
// ROM download bus: ioctl byte stream in, SDRAM/PROM programming writes out.
// No latency of its own; the slave side is the programmer, the master side the loader/memory.
// Backpressure comes only from sdram_ack on the SDRAM write path.
interface jtbubl_prog_if;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        sdram_ack;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prom_we;
    logic        dwnld_busy;
    logic        tokio;
    logic        overflow;

    modport master (
        output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
        input  prog_addr, prog_data, prog_mask, prog_we, prom_we,
               dwnld_busy, tokio, overflow
    );

    modport slave (
        input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
        output prog_addr, prog_data, prog_mask, prog_we, prom_we,
               dwnld_busy, tokio, overflow
    );
endinterface

// File: rtl/jtbubl_prog.sv
// Routes downloaded ROM bytes to SDRAM byte-lane writes or PROM writes via a 2-entry queue.
// Latency: 1 cycle ioctl_wr -> prog_we/prom_we when empty; PROM strobe lasts 1 cycle.
// Backpressure: SDRAM entry held until sdram_ack; one skid entry, further bytes dropped (overflow).
module jtbubl_prog #(
    parameter logic [24:0] PROM_START = 25'hC_0000
) (
    input  logic           clk,
    input  logic           rst,
    jtbubl_prog_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SDWR   = 2'd1,
        PROMWR = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic [21:0] out_addr;
    logic [7:0]  out_data;
    logic [1:0]  out_mask;

    logic        skid_vld;
    logic        skid_prom;
    logic [21:0] skid_addr;
    logic [7:0]  skid_data;
    logic [1:0]  skid_mask;

    logic        in_prom;
    logic [21:0] in_addr;
    logic [1:0]  in_mask;

    logic        out_full;
    logic        pop;
    logic        ld_from_skid;
    logic        ld_from_in;
    logic        skid_wr;
    logic        skid_clr;
    logic        drop;

    logic        dl_last;
    logic        overflow_q;
    logic        tokio_q;

    // Decode the incoming byte into a queue entry
    always_comb begin
        in_prom = bus.ioctl_addr >= PROM_START;
        if (in_prom) begin
            in_addr = bus.ioctl_addr[21:0] - PROM_START[21:0];
            in_mask = 2'b11;
        end else begin
            in_addr = bus.ioctl_addr[22:1];
            in_mask = bus.ioctl_addr[0] ? 2'b01 : 2'b10;
        end
    end

    assign out_full = state != IDLE;
    assign pop      = (state == PROMWR) || (state == SDWR && bus.sdram_ack);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Queue control: the output register refills from the skid first to keep FIFO order
    always_comb begin
        state_nxt    = state;
        ld_from_skid = 1'b0;
        ld_from_in   = 1'b0;
        skid_wr      = 1'b0;
        skid_clr     = 1'b0;
        drop         = 1'b0;
        if (!out_full || pop) begin
            if (skid_vld) begin
                ld_from_skid = 1'b1;
                state_nxt    = skid_prom ? PROMWR : SDWR;
                if (bus.ioctl_wr) skid_wr  = 1'b1;
                else              skid_clr = 1'b1;
            end else if (bus.ioctl_wr) begin
                ld_from_in = 1'b1;
                state_nxt  = in_prom ? PROMWR : SDWR;
            end else begin
                state_nxt = IDLE;
            end
        end else if (bus.ioctl_wr) begin
            if (!skid_vld) skid_wr = 1'b1;
            else           drop    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr <= '0;
            out_data <= '0;
            out_mask <= 2'b11;
        end else if (ld_from_skid) begin
            out_addr <= skid_addr;
            out_data <= skid_data;
            out_mask <= skid_mask;
        end else if (ld_from_in) begin
            out_addr <= in_addr;
            out_data <= bus.ioctl_data;
            out_mask <= in_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_vld  <= 1'b0;
            skid_prom <= 1'b0;
            skid_addr <= '0;
            skid_data <= '0;
            skid_mask <= 2'b11;
        end else if (skid_wr) begin
            skid_vld  <= 1'b1;
            skid_prom <= in_prom;
            skid_addr <= in_addr;
            skid_data <= bus.ioctl_data;
            skid_mask <= in_mask;
        end else if (skid_clr) begin
            skid_vld  <= 1'b0;
        end
    end

    // A new download clears the sticky flag; a drop on that same edge still registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_last    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            dl_last <= bus.downloading;
            if (drop)
                overflow_q <= 1'b1;
            else if (bus.downloading && !dl_last)
                overflow_q <= 1'b0;
        end
    end

    // Game variant survives reset: it is only known from the ROM image itself
    always_ff @(posedge clk) begin
        if (!rst && bus.ioctl_wr && bus.ioctl_addr == 25'd0)
            tokio_q <= bus.ioctl_data == 8'h7E;
    end

    assign bus.prog_addr  = out_addr;
    assign bus.prog_data  = out_data;
    assign bus.prog_mask  = out_mask;
    assign bus.prog_we    = state == SDWR;
    assign bus.prom_we    = state == PROMWR;
    assign bus.dwnld_busy = bus.downloading | out_full | skid_vld;
    assign bus.overflow   = overflow_q;
    assign bus.tokio      = tokio_q;

endmodule

// File: tb/tb_jtbubl_prog.sv
// Directed vector bench for jtbubl_prog: one table row per clock cycle plus hand sequences.
module tb_jtbubl_prog;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    jtbubl_prog_if bus ();

    jtbubl_prog #(.PROM_START(25'hC_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        dl;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  data;
        logic        ack;
        logic        pwe;
        logic        rwe;
        logic [21:0] paddr;
        logic [7:0]  pdata;
        logic [1:0]  pmask;
        logic        busy;
        logic        ovf;
        logic        tkc;
        logic        tk;
    } vec_t;

    vec_t tv[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic mon_en = 1'b0;

    function automatic vec_t mk(
        input logic r, input logic dl, input logic wr, input logic [24:0] a,
        input logic [7:0] d, input logic ack,
        input logic pwe, input logic rwe, input logic [21:0] pa, input logic [7:0] pd,
        input logic [1:0] pm, input logic busy, input logic ovf,
        input logic tkc, input logic tk);
        vec_t v;
        v.rst = r;   v.dl = dl;   v.wr = wr;   v.addr = a;   v.data = d;   v.ack = ack;
        v.pwe = pwe; v.rwe = rwe; v.paddr = pa; v.pdata = pd; v.pmask = pm;
        v.busy = busy; v.ovf = ovf; v.tkc = tkc; v.tk = tk;
        return v;
    endfunction

    task automatic drive(input logic r, input logic dl, input logic wr,
                         input logic [24:0] a, input logic [7:0] d, input logic ack);
        rst             = r;
        bus.downloading = dl;
        bus.ioctl_wr    = wr;
        bus.ioctl_addr  = a;
        bus.ioctl_data  = d;
        bus.sdram_ack   = ack;
    endtask

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] outs();
        return {bus.prog_we, bus.prom_we, bus.prog_addr, bus.prog_data, bus.prog_mask,
                bus.dwnld_busy, bus.overflow};
    endfunction

    // Both write strobes must never be high in the same cycle
    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (bus.prog_we && bus.prom_we) begin
                n_miss++;
                $display("FAIL strobe_overlap: prog_we=%b prom_we=%b expected not both 1",
                         bus.prog_we, bus.prom_we);
            end
        end
    end

    initial begin
        logic [35:0] held;

        drive(1'b1, 1'b0, 1'b0, 25'd0, 8'd0, 1'b0);

        //            rst dl wr addr         data   ack  pwe rwe paddr       pdata  pmask  busy ovf tkc tk
        tv.push_back(mk(1, 0, 0, 25'h0,      8'h00, 0,   0,  0,  22'h0,      8'h00, 2'b11, 0,   0,  0,  0)); // 0 reset
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 0,   0,  0,  22'h0,      8'h00, 2'b11, 1,   0,  0,  0));
        tv.push_back(mk(0, 1, 1, 25'h3,      8'h5A, 0,   1,  0,  22'h1,      8'h5A, 2'b01, 1,   0,  0,  0)); // 2 odd byte
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 0,   1,  0,  22'h1,      8'h5A, 2'b01, 1,   0,  0,  0));
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 0,   1,  0,  22'h1,      8'h5A, 2'b01, 1,   0,  0,  0));
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 1,   0,  0,  22'h1,      8'h5A, 2'b01, 1,   0,  0,  0)); // 5 ack
        tv.push_back(mk(0, 1, 1, 25'hC0010,  8'h0F, 0,   0,  1,  22'h10,     8'h0F, 2'b11, 1,   0,  0,  0)); // 6 PROM
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 0,   0,  0,  22'h10,     8'h0F, 2'b11, 1,   0,  0,  0));
        tv.push_back(mk(0, 1, 1, 25'h100,    8'h11, 0,   1,  0,  22'h80,     8'h11, 2'b10, 1,   0,  0,  0)); // 8 burst
        tv.push_back(mk(0, 1, 1, 25'h101,    8'h22, 0,   1,  0,  22'h80,     8'h11, 2'b10, 1,   0,  0,  0));
        tv.push_back(mk(0, 1, 1, 25'h102,    8'h33, 0,   1,  0,  22'h80,     8'h11, 2'b10, 1,   1,  0,  0)); // 10 drop
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 1,   1,  0,  22'h80,     8'h22, 2'b01, 1,   1,  0,  0));
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 1,   0,  0,  22'h80,     8'h22, 2'b01, 1,   1,  0,  0));
        tv.push_back(mk(0, 0, 0, 25'h0,      8'h00, 0,   0,  0,  22'h80,     8'h22, 2'b01, 0,   1,  0,  0)); // 13 dl low
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 0,   0,  0,  22'h80,     8'h22, 2'b01, 1,   0,  0,  0)); // 14 dl rise
        tv.push_back(mk(0, 1, 1, 25'h200,    8'h44, 0,   1,  0,  22'h100,    8'h44, 2'b10, 1,   0,  0,  0)); // 15
        tv.push_back(mk(0, 1, 1, 25'hC0005,  8'h55, 0,   1,  0,  22'h100,    8'h44, 2'b10, 1,   0,  0,  0)); // PROM to skid
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 1,   0,  1,  22'h5,      8'h55, 2'b11, 1,   0,  0,  0));
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 0,   0,  0,  22'h5,      8'h55, 2'b11, 1,   0,  0,  0));
        tv.push_back(mk(0, 1, 1, 25'h201,    8'h66, 0,   1,  0,  22'h100,    8'h66, 2'b01, 1,   0,  0,  0)); // 19
        tv.push_back(mk(0, 1, 1, 25'hC0001,  8'h77, 1,   0,  1,  22'h1,      8'h77, 2'b11, 1,   0,  0,  0)); // pop+bypass
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 1,   0,  0,  22'h1,      8'h77, 2'b11, 1,   0,  0,  0));
        tv.push_back(mk(0, 1, 1, 25'hC0002,  8'h88, 0,   0,  1,  22'h2,      8'h88, 2'b11, 1,   0,  0,  0)); // 22
        tv.push_back(mk(0, 1, 1, 25'h4,      8'h99, 0,   1,  0,  22'h2,      8'h99, 2'b10, 1,   0,  0,  0)); // PROM->SDRAM
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 1,   0,  0,  22'h2,      8'h99, 2'b10, 1,   0,  0,  0));
        tv.push_back(mk(0, 1, 1, 25'h0,      8'h7E, 0,   1,  0,  22'h0,      8'h7E, 2'b10, 1,   0,  1,  1)); // 25 tokio
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 1,   0,  0,  22'h0,      8'h7E, 2'b10, 1,   0,  1,  1));
        tv.push_back(mk(1, 1, 0, 25'h0,      8'h00, 0,   0,  0,  22'h0,      8'h00, 2'b11, 1,   0,  1,  1)); // 27 rst keeps tokio
        tv.push_back(mk(0, 1, 1, 25'h0,      8'h00, 0,   1,  0,  22'h0,      8'h00, 2'b10, 1,   0,  1,  0));
        tv.push_back(mk(0, 1, 0, 25'h0,      8'h00, 1,   0,  0,  22'h0,      8'h00, 2'b10, 1,   0,  1,  0));
        tv.push_back(mk(0, 1, 1, 25'h10,     8'hA1, 0,   1,  0,  22'h8,      8'hA1, 2'b10, 1,   0,  0,  0)); // 30
        tv.push_back(mk(0, 1, 1, 25'h11,     8'hA2, 0,   1,  0,  22'h8,      8'hA1, 2'b10, 1,   0,  0,  0));
        tv.push_back(mk(1, 1, 1, 25'h12,     8'hA3, 0,   0,  0,  22'h0,      8'h00, 2'b11, 1,   0,  1,  0)); // rst mid-SDWR
        tv.push_back(mk(0, 0, 0, 25'h0,      8'h00, 1,   0,  0,  22'h0,      8'h00, 2'b11, 0,   0,  0,  0));
        tv.push_back(mk(0, 0, 0, 25'h0,      8'h00, 0,   0,  0,  22'h0,      8'h00, 2'b11, 0,   0,  0,  0));
        tv.push_back(mk(0, 0, 1, 25'hBFFFF,  8'hB1, 0,   1,  0,  22'h5FFFF,  8'hB1, 2'b01, 1,   0,  0,  0)); // 35 last SDRAM
        tv.push_back(mk(0, 0, 0, 25'h0,      8'h00, 1,   0,  0,  22'h5FFFF,  8'hB1, 2'b01, 0,   0,  0,  0));
        tv.push_back(mk(0, 0, 1, 25'hC0000,  8'hC1, 0,   0,  1,  22'h0,      8'hC1, 2'b11, 1,   0,  0,  0)); // first PROM
        tv.push_back(mk(0, 0, 0, 25'h0,      8'h00, 0,   0,  0,  22'h0,      8'hC1, 2'b11, 0,   0,  0,  0));
        tv.push_back(mk(0, 0, 1, 25'h1FFFFFF,8'hD1, 0,   0,  1,  22'h33FFFF, 8'hD1, 2'b11, 1,   0,  0,  0)); // top address
        tv.push_back(mk(0, 0, 0, 25'h0,      8'h00, 0,   0,  0,  22'h33FFFF, 8'hD1, 2'b11, 0,   0,  1,  0));

        @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].dl, tv[i].wr, tv[i].addr, tv[i].data, tv[i].ack);
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(),
                {tv[i].pwe, tv[i].rwe, tv[i].paddr, tv[i].pdata, tv[i].pmask, tv[i].busy, tv[i].ovf});
            if (tv[i].tkc)
                chk($sformatf("vec%0d_tokio", i), {35'd0, bus.tokio}, {35'd0, tv[i].tk});
        end

        // Long ack wait: the pending write must stay frozen until acknowledged
        drive(1'b0, 1'b1, 1'b1, 25'h20, 8'hE1, 1'b0);
        @(negedge clk);
        held = {1'b1, 1'b0, 22'h10, 8'hE1, 2'b10, 1'b1, 1'b0};
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b1, 1'b0, 25'h0, 8'h00, 1'b0);
            @(negedge clk);
            chk($sformatf("hold%0d", c), outs(), held);
        end
        drive(1'b0, 1'b1, 1'b0, 25'h0, 8'h00, 1'b1);
        @(negedge clk);
        chk("hold_ack", outs(), {1'b0, 1'b0, 22'h10, 8'hE1, 2'b10, 1'b1, 1'b0});

        // Overflow stays sticky across a download drop and clears on the next rising edge
        drive(1'b0, 1'b1, 1'b1, 25'h30, 8'hF1, 1'b0); @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 25'h31, 8'hF2, 1'b0); @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 25'h32, 8'hF3, 1'b0); @(negedge clk);
        chk("ovf_set", {35'd0, bus.overflow}, 36'd1);
        drive(1'b0, 1'b0, 1'b0, 25'h0, 8'h00, 1'b1); @(negedge clk);
        chk("drain1", outs(), {1'b1, 1'b0, 22'h18, 8'hF2, 2'b01, 1'b1, 1'b1});
        drive(1'b0, 1'b0, 1'b0, 25'h0, 8'h00, 1'b1); @(negedge clk);
        chk("drain2", outs(), {1'b0, 1'b0, 22'h18, 8'hF2, 2'b01, 1'b0, 1'b1});
        drive(1'b0, 1'b1, 1'b0, 25'h0, 8'h00, 1'b0); @(negedge clk);
        chk("ovf_clr", {35'd0, bus.overflow}, 36'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/jtbubl_prog.md
JTBUBL_PROG -- requirements
Module: jtbubl_prog

Interface
REQ-001 Parameter PROM_START, default 25'hC_0000, first ioctl byte address routed to the PROM path instead of SDRAM.
REQ-002 clk  in  1  system clock; single clock domain; every register updates on its rising edge.
REQ-003 rst  in  1  reset; synchronous to clk, active-high.
REQ-004 downloading  in  1  ROM download in progress.
REQ-005 ioctl_addr  in  25  byte address of the incoming ROM byte.
REQ-006 ioctl_data  in  8  incoming ROM byte.
REQ-007 ioctl_wr  in  1  one-cycle strobe; ioctl_addr and ioctl_data are valid with it.
REQ-008 sdram_ack  in  1  SDRAM accepted the current write.
REQ-009 prog_addr  out  22  SDRAM word address, or PROM byte offset on the PROM path.
REQ-010 prog_data  out  8  byte to write.
REQ-011 prog_mask  out  2  active-low byte lane mask.
REQ-012 prog_we  out  1  SDRAM write request; held until acknowledged.
REQ-013 prom_we  out  1  one-cycle PROM write strobe.
REQ-014 dwnld_busy  out  1  download or queued writes outstanding.
REQ-015 tokio  out  1  game-variant flag.
REQ-016 overflow  out  1  sticky flag; a byte was dropped.

Function
REQ-017 Each ioctl_wr with ioctl_addr < PROM_START shall enqueue an SDRAM entry with addr = ioctl_addr[22:1], data = ioctl_data, mask = 2'b10 when ioctl_addr[0]=0 and 2'b01 when ioctl_addr[0]=1.
REQ-018 Each ioctl_wr with ioctl_addr >= PROM_START shall enqueue a PROM entry with addr = (ioctl_addr - PROM_START)[21:0], mask = 2'b11.
REQ-019 The queue shall have two entries: an output register and one skid register, in strict FIFO order.
REQ-020 Output register states: IDLE (empty), SDWR (SDRAM entry presented), PROMWR (PROM entry presented).
REQ-021 IDLE: an entry present at a clock edge (skid, or else the incoming byte) shall load into the output register, giving prog_we or prom_we high the next cycle; latency from ioctl_wr to the strobe is 1 cycle when the queue is empty.
REQ-022 SDWR: prog_we=1 and prog_addr/prog_data/prog_mask shall stay stable until the first cycle sdram_ack=1; on that edge the output register shall pop.
REQ-023 PROMWR: prom_we=1 for exactly one cycle, then the output register shall pop; sdram_ack is ignored on the PROM path.
REQ-024 On a pop with the skid full, the skid entry shall move to the output register on the same edge; with the skid empty and ioctl_wr=1, the incoming byte shall go straight to the output register.
REQ-025 ioctl_wr while the output register is full and not popping shall store the byte in the skid register.
REQ-026 ioctl_wr while both registers are full and not popping shall drop the byte and set overflow; overflow shall stay set until rst or a rising edge of downloading.
REQ-027 Back-to-back SDRAM and PROM entries shall never assert prog_we and prom_we in the same cycle.
REQ-028 dwnld_busy = downloading | output register full | skid full; a falling edge of downloading shall not discard queued entries.
REQ-029 On ioctl_wr with ioctl_addr == 0, tokio shall load (ioctl_data == 8'h7E); tokio shall otherwise hold, including across rst.
REQ-030 When prog_we=0 and prom_we=0, prog_addr, prog_data and prog_mask shall hold their last values.

Reset
REQ-031 rst shall clear the queue (IDLE, skid empty), prog_we=0, prom_we=0, overflow=0, prog_addr=0, prog_data=0, prog_mask=2'b11; it shall not change tokio.
REQ-032 rst asserted during SDWR shall abandon the pending write with no ack wait; a simultaneous ioctl_wr shall be ignored.

Verification
REQ-033 Queue empty, ioctl_wr at addr 0x00003, data 0x5A, ack 3 cycles later -> next cycle prog_we=1, prog_addr=0x00001, mask=2'b01; prog_we drops the cycle after ack.
REQ-034 ioctl_wr at 0xC0010, data 0x0F -> prom_we high exactly 1 cycle, prog_addr=0x00010, prog_data=0x0F, prog_we=0.
REQ-035 Three ioctl_wr on consecutive cycles, no ack -> first two held in order; third dropped; overflow=1; after two acks the two writes appear in order, prog_we=0, dwnld_busy follows downloading.
REQ-036 SDRAM write pending, PROM byte queued in skid, ack -> prom_we the next cycle; prog_we and prom_we never high together.
REQ-037 ioctl_wr at addr 0 with data 0x7E -> tokio=1; rst -> tokio stays 1; a later addr-0 byte 0x00 -> tokio=0.
REQ-038 rst mid-SDWR with the skid full -> next cycle prog_we=0, dwnld_busy=downloading, no later write issued.
